// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line and oversample tick in, received word and status out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_serial;
  logic                 oversample_tick;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 rx_busy;

  modport master (
    output rx_serial, oversample_tick,
    input  data_out, rx_valid, parity_err, frame_err, break_det, rx_busy
  );

  modport slave (
    input  rx_serial, oversample_tick,
    output data_out, rx_valid, parity_err, frame_err, break_det, rx_busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 3-sample majority vote, false-start rejection,
// and parity/framing/break status held until the next completed frame.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_param_if.slave bus
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_next;
  logic                 r_sync1, r_rx_s, r_rx_prev;
  logic [CW-1:0]        r_sample_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_v0, r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err, r_par_bit, r_stop_any0, r_stop_all0;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_rx_valid, r_parity_err, r_frame_err, r_break_det;

  logic w_fall, w_busy_tick, w_cnt_last, w_vote_tick, w_vote, w_bit_end;
  logic w_data_done, w_last_stop, w_frame_done, w_busy;

  assign w_fall       = r_rx_prev & ~r_rx_s;
  assign w_busy_tick  = bus.oversample_tick && (r_state != S_IDLE);
  assign w_cnt_last   = (r_sample_cnt == CW'(OVERSAMPLE - 1));
  assign w_vote_tick  = w_busy_tick && (r_sample_cnt == CW'(M + 1));
  assign w_vote       = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
  assign w_bit_end    = w_busy_tick && w_cnt_last;
  assign w_data_done  = (r_bit_cnt == 4'(DATA_BITS));
  assign w_last_stop  = (r_bit_cnt == 4'(STOP_BITS - 1));
  // Frame completes mid final stop bit so the next start edge is caught early.
  assign w_frame_done = (r_state == S_STOP) && w_vote_tick && w_last_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.rx_serial;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_vote_tick && w_vote) w_next = S_IDLE;
                else if (w_bit_end) w_next = S_DATA;
      S_DATA:   if (w_bit_end && w_data_done) w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_frame_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
    end else begin
      if (w_busy_tick) r_sample_cnt <= w_cnt_last ? '0 : r_sample_cnt + 1'b1;
      if ((r_state == S_DATA && w_bit_end && w_data_done) || (r_state == S_PARITY && w_bit_end))
        r_bit_cnt <= '0;
      else if (w_vote_tick && (r_state == S_DATA || (r_state == S_STOP && !w_last_stop)))
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_par_bit    <= 1'b0;
      r_stop_any0  <= 1'b0;
      r_stop_all0  <= 1'b1;
      r_data_out   <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_busy_tick && r_sample_cnt == CW'(M - 1)) r_v0 <= r_rx_s;
      if (w_busy_tick && r_sample_cnt == CW'(M))     r_v1 <= r_rx_s;
      if (r_state == S_IDLE && w_fall) begin
        r_par_err   <= 1'b0;
        r_par_bit   <= 1'b0;
        r_stop_any0 <= 1'b0;
        r_stop_all0 <= 1'b1;
      end
      if (w_vote_tick) begin
        case (r_state)
          S_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          S_PARITY: begin
            r_par_bit <= w_vote;
            r_par_err <= w_vote != (^r_shift ^ (PARITY_ODD != 0));
          end
          S_STOP: begin
            r_stop_any0 <= r_stop_any0 | ~w_vote;
            r_stop_all0 <= r_stop_all0 & ~w_vote;
          end
          default: ;
        endcase
      end
      // Final stop vote is folded in directly since its register update lands this same edge.
      if (w_frame_done) begin
        r_data_out   <= r_shift;
        r_parity_err <= r_par_err;
        r_frame_err  <= r_stop_any0 | ~w_vote;
        r_break_det  <= (r_shift == '0) && ((PARITY_EN == 0) || !r_par_bit) && r_stop_all0 && !w_vote;
        r_rx_valid   <= 1'b1;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.break_det  = r_break_det;
  assign bus.rx_busy    = w_busy;
endmodule
